// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative MULTU/DIVU engine sharing the EX-stage 32-bit ALU.
// One ADDU (multiply) or SUBU (restoring divide) is issued per cycle for 32
// cycles; the result is committed to the architectural HI/LO registers at the
// end. MTHI/MTLO write HI/LO directly from IDLE without stalling.
module muldiv_sequencer #(
  parameter logic [3:0] OP_ADDU = 4'b0011,
  parameter logic [3:0] OP_SUBU = 4'b0111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_result
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [1:0] CMD_MULTU = 2'b00;
  localparam logic [1:0] CMD_DIVU  = 2'b01;
  localparam logic [1:0] CMD_MTHI  = 2'b10;
  localparam logic [1:0] CMD_MTLO  = 2'b11;

  logic [1:0]  state_q, state_d;
  logic [31:0] acc_q,   acc_d;    // multiply partial product (upper half)
  logic [31:0] mcand_q, mcand_d;  // multiplicand
  logic [31:0] rem_q,   rem_d;    // divide partial remainder
  logic [31:0] dvsr_q,  dvsr_d;   // divisor
  logic [31:0] mq_q,    mq_d;     // multiplier/lower product, or dividend/quotient
  logic [4:0]  cnt_q,   cnt_d;
  logic [31:0] hi_q,    hi_d;
  logic [31:0] lo_q,    lo_d;

  logic        mul_carry;
  logic [32:0] div_s;
  logic        div_ge;

  // Operand steering for the shared ALU plus the per-iteration helper terms.
  always_comb begin
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = OP_ADDU;
    div_s     = {rem_q, mq_q[31]};
    div_ge    = div_s[32] | (div_s[31:0] >= dvsr_q);
    mul_carry = (alu_result < acc_q);
    case (state_q)
      ST_MUL: begin
        alu_a  = acc_q;
        alu_b  = mcand_q;
        alu_op = OP_ADDU;
      end
      ST_DIV: begin
        alu_a  = div_s[31:0];
        alu_b  = dvsr_q;
        alu_op = OP_SUBU;
      end
      default: begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = OP_ADDU;
      end
    endcase
  end

  // Next-state, datapath and HI/LO commit logic.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    rem_d   = rem_q;
    dvsr_d  = dvsr_q;
    mq_d    = mq_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            CMD_MULTU: begin
              state_d = ST_MUL;
              acc_d   = '0;
              mq_d    = rt_val;
              mcand_d = rs_val;
              cnt_d   = '0;
            end
            CMD_DIVU: begin
              state_d = ST_DIV;
              rem_d   = '0;
              mq_d    = rs_val;
              dvsr_d  = rt_val;
              cnt_d   = '0;
            end
            CMD_MTHI: hi_d = rs_val;
            CMD_MTLO: lo_d = rs_val;
            default:  ;
          endcase
        end
      end
      ST_MUL: begin
        // 65-bit {carry,sum,mq} shifted right by one, split across acc/mq.
        if (mq_q[0]) begin
          acc_d = {mul_carry, alu_result[31:1]};
          mq_d  = {alu_result[0], mq_q[31:1]};
        end else begin
          acc_d = {1'b0, acc_q[31:1]};
          mq_d  = {acc_q[0], mq_q[31:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = ST_DONE;
          hi_d    = acc_d;
          lo_d    = mq_d;
        end
      end
      ST_DIV: begin
        rem_d = div_ge ? alu_result : div_s[31:0];
        mq_d  = {mq_q[30:0], div_ge};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = ST_DONE;
          hi_d    = rem_d;
          lo_d    = mq_d;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      rem_q   <= '0;
      dvsr_q  <= '0;
      mq_q    <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      rem_q   <= rem_d;
      dvsr_q  <= dvsr_d;
      mq_q    <= mq_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Status and architectural outputs decoded from registered state.
  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
    hi   = hi_q;
    lo   = lo_q;
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed testbench for muldiv_sequencer with a behavioural ALU model.
module tb_muldiv_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer #(.OP_ADDU(4'b0011), .OP_SUBU(4'b0111)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU: ADDU / SUBU only.
  always_comb begin
    if (alu_op == 4'b0111) alu_result = alu_a - alu_b;
    else if (alu_op == 4'b0011) alu_result = alu_a + alu_b;
    else alu_result = 32'hDEADBEEF;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one MULTU/DIVU, verify latency, HI hold, ALU op, result and pulse.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic hold_start);
    int n;
    logic [31:0] old_hi;
    logic [3:0]  exp_aop;
    logic        bad_aop;
    logic        bad_hold;
    int          done_cnt;
    exp_aop  = (o == 2'b01) ? 4'b0111 : 4'b0011;
    bad_aop  = 1'b0;
    bad_hold = 1'b0;
    done_cnt = 0;
    @(negedge clk);
    old_hi = hi;
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(negedge clk);
    n = 1;
    if (!hold_start) start = 1'b0;
    // inputs are don't-care once accepted
    rs_val = ~a; rt_val = ~b; op = ~o;
    check({tag, " busy_after_start"}, {31'd0, busy}, 32'd1);
    while (!done && n < 40) begin
      if (alu_op !== exp_aop) bad_aop = 1'b1;
      if (hi !== old_hi) bad_hold = 1'b1;
      @(negedge clk);
      n++;
    end
    if (done) done_cnt++;
    start = 1'b0;
    check({tag, " latency"}, n, 33);
    check({tag, " alu_op"}, {31'd0, bad_aop}, 32'd0);
    check({tag, " hi_hold"}, {31'd0, bad_hold}, 32'd0);
    check({tag, " hi"}, hi, exp_hi);
    check({tag, " lo"}, lo, exp_lo);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (k == 0) check({tag, " busy_clear"}, {31'd0, busy}, 32'd0);
    end
    check({tag, " done_count"}, done_cnt, 1);
    check({tag, " hi_stable"}, hi, exp_hi);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
    @(negedge clk);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst hi", hi, 32'd0);
    check("rst lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle alu_a", alu_a, 32'd0);
    check("idle alu_op", {28'd0, alu_op}, 32'h3);

    run_op("mul_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op("mul_zero", 2'b00, 32'd12345, 32'd0, 32'd0, 32'd0, 1'b0);
    run_op("mul_2p32", 2'b00, 32'h00010000, 32'h00010000, 32'd1, 32'd0, 1'b0);
    run_op("div_100_7", 2'b01, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_op("div_msb", 2'b01, 32'h80000000, 32'd1, 32'd0, 32'h80000000, 1'b0);
    run_op("div_small", 2'b01, 32'd7, 32'd100, 32'd7, 32'd0, 1'b0);
    run_op("div_zero", 2'b01, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF, 1'b0);

    // MTHI / MTLO: immediate, no busy, no done
    @(negedge clk);
    start = 1'b1; op = 2'b10; rs_val = 32'hCAFEF00D;
    @(negedge clk);
    start = 1'b0;
    check("mthi hi", hi, 32'hCAFEF00D);
    check("mthi busy", {31'd0, busy}, 32'd0);
    check("mthi done", {31'd0, done}, 32'd0);
    start = 1'b1; op = 2'b11; rs_val = 32'h0BADC0DE;
    @(negedge clk);
    start = 1'b0;
    check("mtlo lo", lo, 32'h0BADC0DE);
    check("mtlo hi", hi, 32'hCAFEF00D);
    check("mtlo busy", {31'd0, busy}, 32'd0);

    // MULTU 3*5 with start held through busy; HI must keep CAFEF00D until commit
    run_op("mul_held", 2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 1'b1);

    // Reset in the middle of a DIVU
    @(negedge clk);
    start = 1'b1; op = 2'b01; rs_val = 32'd1000; rt_val = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("rst_mid busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid busy", {31'd0, busy}, 32'd0);
    check("rst_mid hi", hi, 32'd0);
    check("rst_mid lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("mul_6_7", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
